// File: rtl/qam_word_sched.sv
// Round-robin word scheduler that feeds one QAM modulator, sending each word LSB-first as 1/2/4-bit symbols.
// Optional per-requester statistics counters are enabled with `define QAM_SCHED_STATS_EN.
module qam_word_sched #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*3-1:0]      req_qam,
  output logic [3:0]              sym_data,
  output logic [2:0]              sym_qam,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_last,
  output logic [1:0]              grant_id,
  output logic                    error
`ifdef QAM_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     word_cnt,
  output logic [15:0]             err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr;
  logic [DATA_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    sym_cnt;
  logic [2:0]          qam_q;
  logic [1:0]          gid_q;
  logic                err_q;

  logic [1:0]          gnt_idx;
  logic                gnt_found;
  logic [DATA_W-1:0]   gnt_data;
  logic [2:0]          gnt_qam;
  logic                gnt_legal;
  logic [CNT_W-1:0]    cnt_load;
  logic [2:0]          bps;
  logic                xfer;
  logic                sym_fire;
  logic                word_done;
  int                  cand;

  // Search from rr_ptr upward with wrap for the first valid requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(cand);
      end
    end
  end

  always_comb begin
    gnt_data  = req_data[gnt_idx*DATA_W +: DATA_W];
    gnt_qam   = req_qam[gnt_idx*3 +: 3];
    gnt_legal = (gnt_qam <= 3'd2);
    xfer      = (state == IDLE) && gnt_found;
    req_ready = '0;
    if (xfer && !rst)
      req_ready = N_REQ'(1) << gnt_idx;
    case (gnt_qam)
      3'd1:    cnt_load = CNT_W'(DATA_W / 2);
      3'd2:    cnt_load = CNT_W'(DATA_W / 4);
      default: cnt_load = CNT_W'(DATA_W);
    endcase
    case (qam_q)
      3'd1:    bps = 3'd2;
      3'd2:    bps = 3'd4;
      default: bps = 3'd1;
    endcase
    sym_fire  = (state == SEND) && sym_ready;
    word_done = sym_fire && (sym_cnt == CNT_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && gnt_legal) state_nxt = SEND;
      SEND:    if (word_done)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sym_valid = (state == SEND);
    sym_last  = (state == SEND) && (sym_cnt == CNT_W'(1));
    sym_data  = 4'd0;
    if (state == SEND) begin
      case (qam_q)
        3'd0:    sym_data = {3'b000, shift_reg[0]};
        3'd1:    sym_data = {2'b00, shift_reg[1:0]};
        3'd2:    sym_data = shift_reg[3:0];
        default: sym_data = 4'd0;
      endcase
    end
    sym_qam  = qam_q;
    grant_id = gid_q;
    error    = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Illegal-mode words are consumed and flagged but never reach SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 2'd0;
      shift_reg <= '0;
      sym_cnt   <= '0;
      qam_q     <= 3'd0;
      gid_q     <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (xfer) begin
        shift_reg <= gnt_data;
        qam_q     <= gnt_qam;
        gid_q     <= gnt_idx;
        rr_ptr    <= (gnt_idx == 2'(N_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
        if (gnt_legal) sym_cnt <= cnt_load;
        else           err_q   <= 1'b1;
      end else if (sym_fire) begin
        shift_reg <= shift_reg >> bps;
        sym_cnt   <= sym_cnt - CNT_W'(1);
      end
    end
  end

`ifdef QAM_SCHED_STATS_EN
  logic [15:0] wc [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) wc[i] <= 16'd0;
      err_cnt <= 16'd0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (word_done && gid_q == 2'(i) && wc[i] != 16'hFFFF)
          wc[i] <= wc[i] + 16'd1;
      if (xfer && !gnt_legal && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) word_cnt[i*16 +: 16] = wc[i];
  end
`endif

endmodule

// File: tb/tb_qam_word_sched.sv
// Bench for qam_word_sched: directed scenarios plus random traffic, all checked against a symbol-queue model.
module tb_qam_word_sched;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_data = '0;
  logic [5:0]  req_qam = '0;
  logic [3:0]  sym_data;
  logic [2:0]  sym_qam;
  logic        sym_valid;
  logic        sym_ready = 1'b0;
  logic        sym_last;
  logic [1:0]  grant_id;
  logic        error;
`ifdef QAM_SCHED_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;
`endif

  qam_word_sched #(.N_REQ(N), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_qam(req_qam),
    .sym_data(sym_data), .sym_qam(sym_qam), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_last(sym_last),
    .grant_id(grant_id), .error(error)
`ifdef QAM_SCHED_STATS_EN
    , .word_cnt(word_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] sym; logic [2:0] qam; logic [1:0] gid; logic last;} exp_t;
  typedef struct {logic [3:0] sym; logic [2:0] qam; logic [1:0] gid; logic last; int cyc;} acc_t;
  typedef struct {int gid; int cyc;} log_t;

  exp_t exp_q[$];
  acc_t acc_q[$];
  log_t acc_log[$];

  int compared = 0;
  int failed = 0;
  int cyc = 0;
  int err_pulses = 0;
  int m_rr = 0;
  logic m_err = 1'b0;
  int m_g, m_mode, m_bps, m_n;
  logic [1:0] m_ready;
  logic [31:0] m_word;
  int m_wc [N];
  int m_ec = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [2:0] m0, input logic [2:0] m1, input logic rdy);
    @(posedge clk);
    #1;
    req_valid = v;
    req_data  = {d1, d0};
    req_qam   = {m1, m0};
    sym_ready = rdy;
  endtask

  task automatic waitSyms(input int n, input int budget, input string name);
    int c = 0;
    while (acc_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (acc_q.size() < n) checkOutput({name, "_timeout"}, acc_q.size(), n);
  endtask

  // Spec rule: symbol k of a word is bits [k*bps +: bps], zero-extended.
  function automatic logic [3:0] symAt(input logic [31:0] w, input int mode, input int k);
    int b;
    b = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
    return 4'((w >> (k * b)) & ((32'd1 << b) - 32'd1));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a queue of expected symbols; the scheduler is idle exactly when it is empty.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_sym_valid", sym_valid, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_sym_last", sym_last, 0);
      checkOutput("rst_sym_data", sym_data, 0);
      checkOutput("rst_sym_qam", sym_qam, 0);
      checkOutput("rst_grant_id", grant_id, 0);
`ifdef QAM_SCHED_STATS_EN
      checkOutput("rst_word_cnt", word_cnt, 0);
      checkOutput("rst_err_cnt", err_cnt, 0);
`endif
      exp_q.delete();
      m_rr = 0;
      m_err = 1'b0;
      m_ec = 0;
      for (int i = 0; i < N; i++) m_wc[i] = 0;
    end else begin
      m_ready = '0;
      m_g = -1;
      if (exp_q.size() == 0)
        for (int k = 0; k < N; k++)
          if (m_g < 0 && req_valid[(m_rr + k) % N]) m_g = (m_rr + k) % N;
      if (m_g >= 0) m_ready[m_g] = 1'b1;

      checkOutput("req_ready", req_ready, m_ready);
      checkOutput("error", error, m_err);
      checkOutput("sym_valid", sym_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        checkOutput("sym_data", sym_data, exp_q[0].sym);
        checkOutput("sym_qam", sym_qam, exp_q[0].qam);
        checkOutput("grant_id", grant_id, exp_q[0].gid);
        checkOutput("sym_last", sym_last, exp_q[0].last);
      end else begin
        checkOutput("idle_sym_last", sym_last, 0);
        checkOutput("idle_sym_data", sym_data, 0);
      end
`ifdef QAM_SCHED_STATS_EN
      checkOutput("word_cnt0", word_cnt[15:0], m_wc[0]);
      checkOutput("word_cnt1", word_cnt[31:16], m_wc[1]);
      checkOutput("err_cnt", err_cnt, m_ec);
`endif

      if (sym_valid && sym_ready)
        acc_q.push_back('{sym: sym_data, qam: sym_qam, gid: grant_id, last: sym_last, cyc: cyc});
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) acc_log.push_back('{gid: i, cyc: cyc});
      if (error) err_pulses++;

      m_err = 1'b0;
      if (exp_q.size() > 0 && sym_ready) begin
        if (exp_q[0].last && m_wc[exp_q[0].gid] < 65535) m_wc[exp_q[0].gid]++;
        void'(exp_q.pop_front());
      end
      if (m_g >= 0) begin
        m_mode = int'((req_qam >> (3 * m_g)) & 6'h7);
        m_word = 32'(req_data >> (32 * m_g));
        if (m_mode <= 2) begin
          m_bps = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 4;
          m_n = 32 / m_bps;
          for (int k = 0; k < m_n; k++)
            exp_q.push_back('{sym: symAt(m_word, m_mode, k), qam: 3'(m_mode),
                              gid: 2'(m_g), last: (k == m_n - 1)});
        end else begin
          m_err = 1'b1;
          if (m_ec < 65535) m_ec++;
        end
        m_rr = (m_g + 1) % N;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d0, d1;
    logic [2:0]  q0, q1;
    int          r;

    for (int k = 0; k < 8; k++) checkOutput("model_m2", symAt(32'h7654_3210, 2, k), k);
    for (int k = 0; k < 4; k++) checkOutput("model_m1", symAt(32'h0000_00E4, 1, k), k);
    checkOutput("model_m0_last", symAt(32'hA5A5_0001, 0, 31), 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single mode-0 word from requester 0.
    acc_q.delete(); acc_log.delete();
    applyStimulus(2'b01, 32'hA5A5_0001, 32'h0, 3'd0, 3'd0, 1'b1);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    waitSyms(32, 60, "m0");
    repeat (3) @(posedge clk);
    checkOutput("m0_count", acc_q.size(), 32);
    if (acc_q.size() == 32 && acc_log.size() == 1) begin
      checkOutput("m0_s0", acc_q[0].sym, 1);
      checkOutput("m0_s1", acc_q[1].sym, 0);
      checkOutput("m0_s2", acc_q[2].sym, 0);
      checkOutput("m0_s29", acc_q[29].sym, 1);
      checkOutput("m0_s30", acc_q[30].sym, 0);
      checkOutput("m0_s31", acc_q[31].sym, 1);
      checkOutput("m0_last31", acc_q[31].last, 1);
      checkOutput("m0_last30", acc_q[30].last, 0);
      checkOutput("m0_first_lat", acc_q[0].cyc - acc_log[0].cyc, 1);
      checkOutput("m0_last_lat", acc_q[31].cyc - acc_log[0].cyc, 32);
    end

    // Mode-2 word from requester 1.
    acc_q.delete(); acc_log.delete();
    applyStimulus(2'b10, 32'h0, 32'h7654_3210, 3'd0, 3'd2, 1'b1);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    waitSyms(8, 30, "m2");
    repeat (3) @(posedge clk);
    checkOutput("m2_count", acc_q.size(), 8);
    if (acc_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        checkOutput("m2_sym", acc_q[k].sym, k);
        checkOutput("m2_qam", acc_q[k].qam, 2);
        checkOutput("m2_gid", acc_q[k].gid, 1);
      end
    end

    // Round robin with both requesters held valid in mode 1.
    acc_q.delete(); acc_log.delete();
    applyStimulus(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 3'd1, 3'd1, 1'b1);
    r = 0;
    while (acc_log.size() < 4 && r < 120) begin
      @(posedge clk);
      r++;
    end
    if (acc_log.size() < 4) checkOutput("rr_timeout", acc_log.size(), 4);
    #1 req_valid = 2'b00;
    waitSyms(64, 40, "rr");
    repeat (3) @(posedge clk);
    checkOutput("rr_words", acc_log.size(), 4);
    checkOutput("rr_syms", acc_q.size(), 64);
    if (acc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("rr_gid", acc_log[i].gid, i % 2);
      for (int i = 1; i < 4; i++) checkOutput("rr_gap", acc_log[i].cyc - acc_log[i-1].cyc, 17);
    end

    // Backpressure during a mode-1 word.
    acc_q.delete(); acc_log.delete();
    applyStimulus(2'b01, 32'h0000_00E4, 32'h0, 3'd1, 3'd0, 1'b1);
    applyStimulus(2'b00, 32'h0000_00E4, 32'h0, 3'd1, 3'd0, 1'b1);
    applyStimulus(2'b00, 32'h0000_00E4, 32'h0, 3'd1, 3'd0, 1'b0);
    applyStimulus(2'b00, 32'h0000_00E4, 32'h0, 3'd1, 3'd0, 1'b0);
    applyStimulus(2'b00, 32'h0000_00E4, 32'h0, 3'd1, 3'd0, 1'b1);
    waitSyms(16, 40, "bp");
    repeat (3) @(posedge clk);
    checkOutput("bp_count", acc_q.size(), 16);
    if (acc_q.size() == 16) begin
      for (int k = 0; k < 4; k++) checkOutput("bp_sym", acc_q[k].sym, k);
      checkOutput("bp_stall", acc_q[1].cyc - acc_q[0].cyc, 3);
    end

    // Illegal mode on requester 1, then confirm the pointer moved to 0.
    acc_q.delete(); acc_log.delete(); err_pulses = 0;
    applyStimulus(2'b10, 32'h0, 32'hDEAD_BEEF, 3'd0, 3'd5, 1'b1);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    repeat (4) @(posedge clk);
    checkOutput("ill_syms", acc_q.size(), 0);
    checkOutput("ill_pulses", err_pulses, 1);
    checkOutput("ill_accepts", acc_log.size(), 1);
`ifdef QAM_SCHED_STATS_EN
    checkOutput("ill_err_cnt", err_cnt, 1);
`endif
    acc_log.delete();
    applyStimulus(2'b11, 32'h0F0F_0F0F, 32'h3333_3333, 3'd2, 3'd2, 1'b1);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    waitSyms(8, 30, "ill_next");
    repeat (3) @(posedge clk);
    if (acc_log.size() >= 1) checkOutput("ill_next_gid", acc_log[0].gid, 0);
    else checkOutput("ill_next_accepts", acc_log.size(), 1);

    // Asynchronous reset in the middle of a mode-0 word.
    acc_q.delete(); acc_log.delete();
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0, 3'd0, 3'd0, 1'b1);
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    waitSyms(3, 20, "rst_mid");
    #2 rst = 1'b1;
    #1;
    checkOutput("async_sym_valid", sym_valid, 0);
    checkOutput("async_sym_last", sym_last, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_q.delete(); acc_log.delete();
    req_valid = 2'b11;
    req_data  = {32'h8765_4321, 32'h1357_9BDF};
    req_qam   = {3'd2, 3'd2};
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    waitSyms(8, 30, "post_rst");
    repeat (5) @(posedge clk);
    checkOutput("post_rst_syms", acc_q.size(), 8);
    if (acc_log.size() >= 1) checkOutput("post_rst_gid", acc_log[0].gid, 0);
    else checkOutput("post_rst_accepts", acc_log.size(), 1);

    // Random traffic: valids, data, modes (some illegal) and backpressure all vary per cycle.
    for (int c = 0; c < 400; c++) begin
      d0 = $urandom;
      d1 = $urandom;
      r = $urandom_range(0, 9);
      q0 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      r = $urandom_range(0, 9);
      q1 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      applyStimulus(2'($urandom_range(0, 3)), d0, d1, q0, q1, $urandom_range(0, 3) != 0);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 1'b1);
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/qam_word_sched.md
Name: qam_word_sched

Overview:
- Round-robin scheduler that shares the single QAM modulator datapath between N_REQ word sources.
- Each source presents a DATA_W-bit word plus its own 3-bit QAM mode.
- The scheduler grants one word at a time and serialises it LSB-first into symbols sized for the mode: 1, 2 or 4 bits.
- It drives the modulator's symbol/select inputs under a valid/ready handshake, and sits between the framing/source logic and the modulator.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- DATA_W, 32, word width; must be a multiple of 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_data  in  N_REQ*DATA_W  flattened words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_qam  in  N_REQ*3  flattened modes; requester i occupies bits [i*3 +: 3]. Encoding: 0 = 1 b/sym, 1 = 2 b/sym, 2 = 4 b/sym, 3..7 illegal.
- sym_data  out  4  current symbol, right-justified; unused upper bits are 0.
- sym_qam  out  3  mode of the current word; drives the modulator select.
- sym_valid  out  1  symbol valid.
- sym_ready  in  1  modulator accepts symbol.
- sym_last  out  1  final symbol of the word.
- grant_id  out  2  index of the requester owning the current word.
- error  out  1  one-cycle pulse when a word with an illegal mode is accepted.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, shift_reg=0, sym_cnt=0, and all outputs 0 (sym_valid, sym_last, req_ready, error, sym_data, sym_qam, grant_id). A word in flight is discarded with no further symbols.
- FSM has two states, IDLE and SEND.
- IDLE arbitration:
  - req_ready is combinational: a one-hot on the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - No valid requester gives req_ready=0.
  - A transfer occurs when req_valid[g] & req_ready[g].
- On transfer from requester g:
  - Latch shift_reg=req_data[g], sym_qam=req_qam[g], grant_id=g; set rr_ptr=(g+1) mod N_REQ.
  - Legal mode: set sym_cnt = DATA_W/bps (32, 16 or 8 at default) and go to SEND.
  - Illegal mode: pulse error for 1 cycle, emit no symbols, stay in IDLE.
- SEND:
  - sym_valid=1; sym_data = shift_reg[bps-1:0], zero-extended.
  - sym_last=1 when sym_cnt==1.
  - req_ready=0 for all requesters.
- On sym_valid & sym_ready: shift_reg >>= bps, sym_cnt -= 1. If sym_cnt was 1, go to IDLE and drop sym_valid next cycle.
- Backpressure: when sym_ready=0, sym_data, sym_qam, sym_last and grant_id hold stable.
- Latency:
  - Word accepted at cycle T; first symbol valid at T+1.
  - With sym_ready held high, the last symbol is at T+DATA_W/bps.
  - IDLE is revisited for exactly 1 cycle between words, so the next accept happens no earlier than T+DATA_W/bps+1.
- Changes to req_qam/req_data after acceptance have no effect on the word in flight.
- Symbol order: bit 0 is sent first; within a 2- or 4-bit symbol, sym_data[0] is word bit k*bps.

Optional Feature:
- Macro: QAM_SCHED_STATS_EN.
- When defined, adds the following outputs:
  - word_cnt, out, N_REQ*16: per-requester count of words completed, i.e. last symbol accepted.
  - err_cnt, out, 16: count of illegal-mode words.
  - All counters saturate at 16'hFFFF and are cleared by rst.
- When undefined, these ports and the counters are absent; behaviour is otherwise identical.

Test Plan:
- Single word, mode 0:
  - Stimulus: req 0 word 32'hA5A5_0001, mode 0, sym_ready=1.
  - Response: 32 symbols; sym_data sequence 1,0,0,0,... ending 1,0,1; sym_last on the 32nd; first sym_valid 1 cycle after accept.
- Mode 2:
  - Stimulus: word 32'h7654_3210.
  - Response: 8 symbols 0,1,2,3,4,5,6,7; sym_qam=2 throughout.
- Round-robin:
  - Stimulus: both requesters held valid with mode 1.
  - Response: grant_id alternates 0,1,0,1; each word gives 16 symbols; 1 idle cycle between words.
- Backpressure:
  - Stimulus: sym_ready toggled 1,0,0,1 during a mode-1 word 32'h0000_00E4.
  - Response: outputs hold during stalls; symbols 0,1,2,3 in order.
- Illegal mode:
  - Stimulus: req 1 with mode 5.
  - Response: word accepted, error high for 1 cycle, no sym_valid, rr_ptr advances to 0. With QAM_SCHED_STATS_EN, err_cnt=1.
- Reset mid-word:
  - Stimulus: assert rst asynchronously after the 3rd symbol of a mode-0 word.
  - Response: sym_valid falls without waiting for a clock edge; after release, the next grant starts from requester 0 and the old word is never resumed.
